// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for the elastic pipeline stage
package pipe_pkg;

   // Encoding is chosen so that the occupancy count equals the state value.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam int PIPE_DEFAULT_WIDTH = 64;

endpackage

// File: rtl/enable_reg.sv
// rtl/enable_reg.sv - load-enabled data register with asynchronous active-low clear
module enable_reg #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Load only when enabled; otherwise hold the stored word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry valid/ready pipeline stage with skid slot
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = PIPE_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   state_t           state;
   state_t           state_next;
   logic             main_en;
   logic             main_from_skid;
   logic             skid_en;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] skid_q;

   // Outputs decode the state register only, so in_ready has no
   // combinational dependence on any input.
   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign count     = state;

   // Next state and slot load enables; flush overrides everything and
   // leaves both slots untouched.
   always_comb begin
      state_next     = state;
      main_en        = 1'b0;
      main_from_skid = 1'b0;
      skid_en        = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_valid) begin
                  main_en    = 1'b1;
                  state_next = ONE;
               end
            end
            ONE: begin
               if (out_ready && in_valid) begin
                  main_en = 1'b1;
               end else if (out_ready) begin
                  state_next = EMPTY;
               end else if (in_valid) begin
                  skid_en    = 1'b1;
                  state_next = TWO;
               end
            end
            TWO: begin
               if (out_ready) begin
                  main_en        = 1'b1;
                  main_from_skid = 1'b1;
                  state_next     = ONE;
               end
            end
            default: begin
               state_next = EMPTY;
            end
         endcase
      end
   end

   // Main slot refills from upstream, or drains the skid slot when full.
   assign main_d = main_from_skid ? skid_q : in_data;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   enable_reg #(.WIDTH(WIDTH)) u_main (
      .clk   (clk),
      .reset (reset),
      .en    (main_en),
      .d     (main_d),
      .q     (out_data)
   );

   enable_reg #(.WIDTH(WIDTH)) u_skid (
      .clk   (clk),
      .reset (reset),
      .en    (skid_en),
      .d     (in_data),
      .q     (skid_q)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;

   localparam int WIDTH = 64;

   logic             clk;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       count;

   int total = 0;
   int bad   = 0;

   pipe_skid_reg #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [1:0] c, input logic ov, input logic ir);
      check({tag, ".count"}, 64'(count), 64'(c));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
      check({tag, ".in_ready"}, 64'(in_ready), 64'(ir));
   endtask

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #2;
      check_state("reset", 2'd0, 1'b0, 1'b1);
      check("reset.out_data", out_data, 64'h0);
      step();
      step();
      reset = 1'b1;

      // empty with out_ready: nothing happens
      out_ready = 1'b1;
      step();
      check_state("empty_ready", 2'd0, 1'b0, 1'b1);

      // streaming 1..8
      in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_data = 64'(i);
         step();
         check($sformatf("stream%0d.data", i), out_data, 64'(i));
         check_state($sformatf("stream%0d", i), 2'd1, 1'b1, 1'b1);
      end
      in_valid = 1'b0;
      step();
      check_state("stream_end", 2'd0, 1'b0, 1'b1);

      // backpressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h11;
      step();
      check_state("bp1", 2'd1, 1'b1, 1'b1);
      check("bp1.data", out_data, 64'h11);
      in_data = 64'h22;
      step();
      check_state("bp2", 2'd2, 1'b1, 1'b0);
      in_data = 64'h33;
      step();
      check_state("bp3", 2'd2, 1'b1, 1'b0);
      check("bp3.data", out_data, 64'h11);
      out_ready = 1'b1;
      step();
      check("bp4.data", out_data, 64'h22);
      check_state("bp4", 2'd1, 1'b1, 1'b1);
      step();
      check("bp5.data", out_data, 64'h33);
      check_state("bp5", 2'd1, 1'b1, 1'b1);
      in_valid = 1'b0;
      step();
      check_state("bp6", 2'd0, 1'b0, 1'b1);

      // full with simultaneous in_valid and out_ready
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h5;
      step();
      in_data = 64'h6;
      step();
      check_state("full_fill", 2'd2, 1'b1, 1'b0);
      in_data   = 64'h7;
      out_ready = 1'b1;
      #3;
      check("full_pre.in_ready", 64'(in_ready), 64'h0);
      step();
      check("full.data", out_data, 64'h6);
      check_state("full", 2'd1, 1'b1, 1'b1);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      step();
      check("full_hold.data", out_data, 64'h6);
      check_state("full_hold", 2'd1, 1'b1, 1'b1);

      // flush from TWO with a beat offered
      in_valid = 1'b1;
      in_data  = 64'h8;
      step();
      check_state("pre_flush", 2'd2, 1'b1, 1'b0);
      flush   = 1'b1;
      in_data = 64'h9;
      step();
      flush = 1'b0;
      check_state("flush", 2'd0, 1'b0, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check_state("post_flush", 2'd0, 1'b0, 1'b1);

      // idle drain from ONE
      in_valid  = 1'b1;
      in_data   = 64'h42;
      out_ready = 1'b0;
      step();
      check("drain.data", out_data, 64'h42);
      check_state("drain_one", 2'd1, 1'b1, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check_state("drain", 2'd0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         out_ready = 1'b0;
         step();
         out_ready = 1'b1;
         step();
         check($sformatf("drain_pulse%0d.out_valid", k), 64'(out_valid), 64'h0);
      end

      // reset mid-stream while full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hA;
      step();
      in_data = 64'hB;
      step();
      check_state("pre_reset", 2'd2, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_state("async_reset", 2'd0, 1'b0, 1'b1);
      check("async_reset.data", out_data, 64'h0);
      step();
      reset   = 1'b1;
      in_data = 64'hC;
      step();
      check("after_reset.data", out_data, 64'hC);
      check_state("after_reset", 2'd1, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
